// File: rtl/output_port.sv
// Memory-mapped output port: queues CPU stores in a small FIFO and drains
// them to the upper seven-segment digits, holding each value for HOLD_CYCLES.
//
// state  | meaning
// S_IDLE | nothing being held; display keeps the last value
// S_SHOW | display value in its hold period; timer counts down to 0
module output_port #(
  parameter int WORD_W      = 8,
  parameter int OP_W        = 3,
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int OUT_ADDR    = 30,
  parameter int STAT_ADDR   = 31
) (
  input  logic              clock,
  input  logic              n_reset,
  inout  wire  [WORD_W-1:0] sysbus,
  input  logic              load_MAR,
  input  logic              CS,
  input  logic              R_NW,
  input  logic              MDR_bus,
  output logic [3:0]        sevSeg0,
  output logic [3:0]        sevSeg1,
  output logic              busy
);

  localparam int ADDR_W = WORD_W - OP_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TMR_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_ADDR);
  localparam logic [ADDR_W-1:0] STAT_A   = ADDR_W'(STAT_ADDR);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [WORD_W-1:0]   mem_d [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [WORD_W-1:0]   disp_q, disp_d;

  logic                wr_sel, rd_stat, empty, full, push, pop;
  logic [WORD_W-1:0]   stat_word;

  always_comb begin
    wr_sel  = CS & ~R_NW & (addr_q == OUT_A);
    rd_stat = CS & R_NW & MDR_bus & (addr_q == STAT_A);
    empty   = (count_q == '0);
    full    = (count_q == CNT_FULL);

    state_d = state_q;
    timer_d = timer_q;
    disp_d  = disp_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          disp_d  = mem_q[rd_ptr_q];
          timer_d = TMR_LOAD;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (timer_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            disp_d  = mem_q[rd_ptr_q];
            timer_d = TMR_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Fullness is judged after a same-cycle pop, so a push into a full
    // queue that is draining this cycle still lands.
    push = wr_sel & (~full | pop);

    ovf_d = ovf_q;
    if (rd_stat)
      ovf_d = 1'b0;
    else if (wr_sel && full && !pop)
      ovf_d = 1'b1;

    mem_d = mem_q;
    if (push)
      mem_d[wr_ptr_q] = sysbus;

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    addr_d   = load_MAR ? sysbus[ADDR_W-1:0] : addr_q;

    stat_word             = '0;
    stat_word[WORD_W-1]   = ovf_q;
    stat_word[WORD_W-2]   = full;
    stat_word[WORD_W-3]   = empty;
    stat_word[2:0]        = 3'(count_q);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      timer_q  <= '0;
      disp_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      timer_q  <= timer_d;
      disp_q   <= disp_d;
    end
  end

  assign sysbus  = rd_stat ? stat_word : {WORD_W{1'bz}};
  assign sevSeg0 = disp_q[3:0];
  assign sevSeg1 = disp_q[7:4];
  assign busy    = (state_q == S_SHOW);

endmodule

// File: doc/output_port.md
Name: output_port

Overview:
- Memory-mapped output responder on the CPU sysbus: the write-side counterpart of the switch input module.
- Stores written in the CPU's store state to OUT_ADDR are queued in a small FIFO.
- A drain state machine presents each byte on the two upper seven-segment digits for HOLD_CYCLES clocks before advancing, so fast store sequences remain visible.
- A status word at STAT_ADDR lets programs poll the queue.

Parameters:
- WORD_W, 8: sysbus and data width.
- OP_W, 3: opcode width; the address field is WORD_W-OP_W bits.
- DEPTH, 4: FIFO entries; power of two, minimum 2.
- HOLD_CYCLES, 50000000: display hold time per value, in clocks; minimum 1.
- OUT_ADDR, 30: address of the data (write) register.
- STAT_ADDR, 31: address of the status (read) register.

Ports:
- clock  input  1  system clock; rising edge.
- n_reset  input  1  asynchronous active-low reset.
- sysbus  inout  WORD_W  shared system bus; driven only during status read, else 'z.
- load_MAR  input  1  address latch strobe; captures sysbus[WORD_W-OP_W-1:0] into the local address register.
- CS  input  1  memory chip select.
- R_NW  input  1  1 = read, 0 = write.
- MDR_bus  input  1  read-data enable onto sysbus.
- sevSeg0  output  4  low nibble of displayed byte.
- sevSeg1  output  4  high nibble of displayed byte.
- busy  output  1  1 while a value is in its hold period.

Behaviour:
- Reset (async, n_reset=0): address register 0, FIFO empty (rd/wr pointers and count 0), overflow 0, state IDLE, hold timer 0, display register 0. Outputs: sevSeg0=0, sevSeg1=0, busy=0, sysbus released.
- Address register: loads at the rising edge when load_MAR=1; otherwise holds.
- Write: at a rising edge with CS=1, R_NW=0, addr==OUT_ADDR:
  - not full: push sysbus;
  - full: data dropped, overflow set (sticky).
  - One push per qualifying edge; the sequencer asserts the write for exactly one cycle.
- Status read:
  - Drive condition (combinational): CS=1, R_NW=1, MDR_bus=1, addr==STAT_ADDR.
  - Status word: bit7 overflow, bit6 full, bit5 empty, bits[2:0] count (0..DEPTH), other bits 0.
  - Overflow clears at the rising edge ending a cycle in which the drive condition held.
  - A write to STAT_ADDR or a read of OUT_ADDR is ignored; no drive, no state change.
- FSM states: IDLE, SHOW.
  - IDLE, FIFO empty: display holds its last value; busy=0.
  - IDLE, FIFO non-empty: at the next edge, pop the head into the display register, load timer=HOLD_CYCLES-1, go to SHOW.
  - SHOW: busy=1; timer decrements each edge.
  - SHOW, timer==0 and FIFO non-empty: pop the next value into the display, reload the timer, stay in SHOW.
  - SHOW, timer==0 and FIFO empty: go to IDLE; the display keeps the value.
- Latency: a write captured at edge k into an empty FIFO in IDLE appears on sevSeg at edge k+1. Each value is displayed for exactly HOLD_CYCLES clocks when the queue is backed up.
- Simultaneous push and pop:
  - Count unchanged, both pointers advance.
  - A push when full coincident with a pop is accepted, not dropped: full is evaluated after the pop.
- Pointers wrap modulo DEPTH. Count saturates at DEPTH; it never wraps.
- sevSeg0 = display[3:0], sevSeg1 = display[7:4]. Registered outputs; no glitches.
- Reset mid-hold: immediate return to reset values; queued data discarded.
- sysbus is never driven during CS=0 or any write cycle. There is no contention with RAM/ROM, because STAT_ADDR is outside their decoded range by system assignment.

Test Plan (HOLD_CYCLES=4, DEPTH=4):
- Reset asserted mid-operation -> sevSeg0/1=0, busy=0, sysbus 'z, status read returns 8'h20.
- Single write 8'hA5 to addr 30 at edge k -> sevSeg1=A, sevSeg0=5 after edge k+1; busy=1 for 4 cycles, then 0; display stays A5.
- Back-to-back writes 11,22,33 -> each shown 4 cycles in order. During the burst, status read shows count 2 then 1. End: IDLE showing 33.
- Six writes while the first is held (01..06) -> entries up to 4 queued; excess writes dropped. Status shows bit7=1, bit6=1; a second status read shows bit7=0. Only non-dropped values are displayed.
- Push coincident with pop while full -> count stays 4; the new value is accepted; no overflow.
- Write to addr 31, and a read of addr 30 with MDR_bus=1 -> no FIFO change, sysbus undriven. Read of addr 31 with MDR_bus=0 -> sysbus undriven.
